alu_operand_fetch: RTL and testbench

ALU_OPERAND_FETCH -- requirements
Module: alu_operand_fetch

---
 rtl/alu_operand_fetch.sv | 44 ++++
 tb/tb_alu_operand_fetch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: gathers two stream words into a registered a/b operand pair with valid/ready handshake
module alu_operand_fetch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [7:0]       pair_cnt
);
  typedef enum logic [1:0] {S_A, S_B, S_OUT} state_t;
  state_t state, nxt;
  logic acc;
  assign in_ready = state != S_OUT;
  assign op_valid = state == S_OUT;
  // flush blocks any load and any count on its edge
  assign acc = in_valid && in_ready && !flush;
  always_comb begin
    nxt = state;
    nxt = flush ? S_A :
          state == S_A ? (acc ? S_B : S_A) :
          state == S_B ? (acc ? S_OUT : S_B) :
          (op_ready ? S_A : S_OUT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_A;
      a        <= '0;
      b        <= '0;
      pair_cnt <= '0;
    end else begin
      state <= nxt;
      if (acc && state == S_A) a <= in_data;
      if (acc && state == S_B) b <= in_data;
      if (state == S_OUT && op_ready && !flush) pair_cnt <= pair_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_operand_fetch.sv
// tb_alu_operand_fetch: directed self-checking bench for alu_operand_fetch
module tb_alu_operand_fetch;
  logic       clk = 0, rst = 0, in_valid = 0, flush = 0, op_ready = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, op_valid;
  logic [7:0] a, b, pair_cnt;
  int checks = 0, failures = 0;
  alu_operand_fetch #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .a(a), .b(b), .op_valid(op_valid), .op_ready(op_ready), .pair_cnt(pair_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    in_valid = 1;
    in_data = d;
    step();
    in_valid = 0;
  endtask
  initial begin
    int nv;
    #1 rst = 1;
    #1;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_cnt", pair_cnt, 0);
    chk("rst_opv", op_valid, 0);
    chk("rst_inr", in_ready, 1);
    step();
    rst = 0;
    // basic pair
    send(8'hF0);
    chk("basic_a", a, 8'hF0);
    chk("basic_opv0", op_valid, 0);
    send(8'h3C);
    chk("basic_b", b, 8'h3C);
    chk("basic_opv1", op_valid, 1);
    chk("basic_inr0", in_ready, 0);
    chk("basic_and", a & b, 8'h30);
    op_ready = 1;
    step();
    op_ready = 0;
    chk("basic_opv_drop", op_valid, 0);
    chk("basic_cnt", pair_cnt, 1);
    // backpressure
    send(8'hAA);
    send(8'h55);
    in_valid = 1;
    in_data = 8'h11;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_opv", op_valid, 1);
      chk("bp_inr", in_ready, 0);
      chk("bp_a", a, 8'hAA);
      chk("bp_b", b, 8'h55);
    end
    chk("bp_cnt_hold", pair_cnt, 1);
    op_ready = 1;
    step();
    op_ready = 0;
    in_valid = 0;
    chk("bp_cnt", pair_cnt, 2);
    chk("bp_ign_a", a, 8'hAA);
    chk("bp_ign_b", b, 8'h55);
    // flush in S_B with a word present
    send(8'h12);
    flush = 1;
    in_valid = 1;
    in_data = 8'h34;
    step();
    flush = 0;
    in_valid = 0;
    chk("fl_a", a, 8'h12);
    chk("fl_b", b, 8'h55);
    chk("fl_inr", in_ready, 1);
    chk("fl_opv", op_valid, 0);
    send(8'h01);
    chk("fl_next_a", a, 8'h01);
    chk("fl_next_b_hold", b, 8'h55);
    chk("fl_next_opv0", op_valid, 0);
    send(8'h02);
    chk("fl_next_b", b, 8'h02);
    chk("fl_next_opv", op_valid, 1);
    op_ready = 1;
    step();
    op_ready = 0;
    chk("fl_cnt", pair_cnt, 3);
    // flush versus handshake
    send(8'h07);
    send(8'h08);
    chk("fh_opv_pre", op_valid, 1);
    flush = 1;
    op_ready = 1;
    step();
    flush = 0;
    op_ready = 0;
    chk("fh_opv", op_valid, 0);
    chk("fh_inr", in_ready, 1);
    chk("fh_cnt", pair_cnt, 3);
    send(8'h09);
    chk("fh_sa", a, 8'h09);
    chk("fh_sa_b", b, 8'h08);
    // wrap: reset then stream 256 pairs
    #2 rst = 1;
    #1 rst = 0;
    chk("wrap_rst_cnt", pair_cnt, 0);
    nv = 0;
    in_valid = 1;
    op_ready = 1;
    for (int i = 1; i <= 768; i++) begin
      in_data = i[7:0];
      step();
      nv += int'(op_valid);
      if (i == 765) chk("wrap_cnt_ff", pair_cnt, 8'hFF);
      if (i == 767) chk("wrap_opv_767", op_valid, 1);
    end
    in_valid = 0;
    op_ready = 0;
    chk("wrap_nvalid", nv, 256);
    chk("wrap_cnt0", pair_cnt, 0);
    chk("wrap_a", a, 8'hFE);
    chk("wrap_b", b, 8'hFF);
    // async reset while in S_OUT
    send(8'h01);
    send(8'h02);
    op_ready = 1;
    step();
    op_ready = 0;
    chk("ar_cnt_pre", pair_cnt, 1);
    send(8'h5A);
    send(8'hC3);
    chk("ar_opv_pre", op_valid, 1);
    #2 rst = 1;
    #1;
    chk("ar_opv", op_valid, 0);
    chk("ar_a", a, 0);
    chk("ar_b", b, 0);
    chk("ar_cnt", pair_cnt, 0);
    chk("ar_inr", in_ready, 1);
    step();
    rst = 0;
    send(8'h77);
    chk("ar_first_a", a, 8'h77);
    chk("ar_first_cnt", pair_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
